// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-port data memory.
// Grants are combinational; the command of the winner is registered toward the
// memory, and read data returns two cycles after the grant on a shared rdata bus.
// Optional build macro DMEM_ARB_FIXED_PRIO_EN: port 0 always wins a tie.
// Without it, ties use ownership with a MAX_BURST limit and a last-grant pointer.
module dmem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);
    localparam logic [3:0] CNT_SAT   = 4'hF;

    // Ownership / fairness state
    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_q, last_d;   // 1 = port 1 was granted most recently

    // Memory-side command and read-return pipeline
    logic              mem_en_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_in_q;
    logic              rd_pend_q;        // a read command sits on mem_addr this cycle
    logic              rd_port_q;        // which port that read belongs to
    logic              rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0] rdata_q;

    logic              win0, win1;

    // Pick this cycle's winner from the requests and the fairness state
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        if (req0 && !req1) begin
            win0 = 1'b1;
        end else if (req1 && !req0) begin
            win1 = 1'b1;
        end else if (req0 && req1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            win0 = 1'b1;
`else
            case (state_q)
                ST_OWN0: begin
                    if (cnt_q < BURST_LIM) win0 = 1'b1;
                    else                   win1 = 1'b1;
                end
                ST_OWN1: begin
                    if (cnt_q < BURST_LIM) win1 = 1'b1;
                    else                   win0 = 1'b1;
                end
                default: begin
                    // Tie from idle: the port not served last time goes first
                    if (last_q) win0 = 1'b1;
                    else        win1 = 1'b1;
                end
            endcase
`endif
        end
    end

    // Grants are forced low while reset is asserted
    assign gnt0 = win0 & rst_n;
    assign gnt1 = win1 & rst_n;

    // Next ownership state, burst count and last-grant pointer
    always_comb begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        last_d  = last_q;
        if (win0) begin
            state_d = ST_OWN0;
            last_d  = 1'b0;
            if (state_q == ST_OWN0) cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 4'd1;
            else                    cnt_d = 4'd1;
        end else if (win1) begin
            state_d = ST_OWN1;
            last_d  = 1'b1;
            if (state_q == ST_OWN1) cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 4'd1;
            else                    cnt_d = 4'd1;
        end
    end

    // Ownership registers; pointer resets to port 1 so the first tie goes to port 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Register the winning command toward the memory; write enable only for writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_in_q   <= '0;
            rd_pend_q  <= 1'b0;
            rd_port_q  <= 1'b0;
        end else begin
            mem_en_q  <= (win0 & we0) | (win1 & we1);
            rd_pend_q <= (win0 & !we0) | (win1 & !we1);
            rd_port_q <= win1;
            if (win0) begin
                mem_addr_q <= addr0;
                mem_in_q   <= wdata0;
            end else if (win1) begin
                mem_addr_q <= addr1;
                mem_in_q   <= wdata1;
            end
        end
    end

    // Capture memory read data one cycle after the command and flag the owning port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rvalid0_q <= rd_pend_q & !rd_port_q;
            rvalid1_q <= rd_pend_q &  rd_port_q;
            if (rd_pend_q) rdata_q <= mem_out;
        end
    end

    assign mem_en   = mem_en_q;
    assign mem_addr = mem_addr_q;
    assign mem_in   = mem_in_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural data memory
// (synchronous write on mem_en, combinational read at mem_addr).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata;
    logic        mem_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_in;
    logic [15:0] mem_out;

    logic [15:0] mem [0:255];

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_en(mem_en), .mem_addr(mem_addr), .mem_in(mem_in),
        .mem_out(mem_out)
    );

    always @(posedge clk) if (mem_en) mem[mem_addr] = mem_in;
    assign mem_out = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drv0(input logic r, input logic w, input logic [7:0] a, input logic [15:0] d);
        req0 = r; we0 = w; addr0 = a; wdata0 = d;
    endtask

    task automatic drv1(input logic r, input logic w, input logic [7:0] a, input logic [15:0] d);
        req1 = r; we1 = w; addr1 = a; wdata1 = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
        $fatal(1);
    end

    initial begin
        logic e1;
        rst_n = 1'b0;
        drv0(1'b1, 1'b1, 8'h05, 16'hFFFF);
        drv1(1'b1, 1'b0, 8'h00, 16'h0000);
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'h0001; mem[1] = 16'h0002; mem[2] = 16'h0003;
        mem[8'h30] = 16'h1111;

        // reset state, requests present but gated
        #3;
        chk("rst_gnt0", gnt0, 0);      chk("rst_gnt1", gnt1, 0);
        chk("rst_rvalid0", rvalid0, 0); chk("rst_rvalid1", rvalid1, 0);
        chk("rst_rdata", rdata, 0);    chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_in", mem_in, 0);
        repeat (2) @(negedge clk);
        #1 chk("rst_hold_mem_en", mem_en, 0);

        // release: first tie in the first active cycle goes to port 0
        rst_n = 1'b1;
        drv0(1'b1, 1'b0, 8'h00, 16'h0); drv1(1'b1, 1'b0, 8'h01, 16'h0);
        #1 chk("tie_gnt0", gnt0, 1); chk("tie_gnt1", gnt1, 0);
        @(negedge clk); drv0(1'b0, 1'b0, 8'h00, 16'h0);
        #1 chk("solo_gnt1", gnt1, 1); chk("solo_gnt0", gnt0, 0);
        @(negedge clk); drv1(1'b0, 1'b0, 8'h00, 16'h0);
        #1 chk("first_rv0", rvalid0, 1); chk("first_rdata0", rdata, 16'h0001);
        @(negedge clk);
        #1 chk("first_rv1", rvalid1, 1); chk("first_rdata1", rdata, 16'h0002);
        chk("first_rv0_off", rvalid0, 0);

        // write then read back on port 0
        @(negedge clk); drv0(1'b1, 1'b1, 8'h05, 16'hABCD);
        #1 chk("wr_gnt0", gnt0, 1);
        @(negedge clk); drv0(1'b0, 1'b0, 8'h00, 16'h0);
        #1 chk("wr_mem_en", mem_en, 1); chk("wr_mem_addr", mem_addr, 8'h05);
        chk("wr_mem_in", mem_in, 16'hABCD);
        @(negedge clk); drv0(1'b1, 1'b0, 8'h05, 16'h0);
        #1 chk("rd_gnt0", gnt0, 1); chk("rd_mem_en_off", mem_en, 0);
        @(negedge clk); drv0(1'b0, 1'b0, 8'h00, 16'h0);
        #1 chk("rd_rv0_early", rvalid0, 0);
        @(negedge clk);
        #1 chk("rd_rv0", rvalid0, 1); chk("rd_rdata", rdata, 16'hABCD);
        chk("rd_rv1_off", rvalid1, 0);
        @(negedge clk);
        #1 chk("rd_rv0_pulse", rvalid0, 0); chk("rd_rdata_hold", rdata, 16'hABCD);

        // write on port 0, read of same address on port 1 next cycle
        @(negedge clk); drv0(1'b1, 1'b1, 8'h10, 16'h1234);
        #1 chk("x_wr_gnt0", gnt0, 1);
        @(negedge clk); drv0(1'b0, 1'b0, 8'h00, 16'h0); drv1(1'b1, 1'b0, 8'h10, 16'h0);
        #1 chk("x_rd_gnt1", gnt1, 1); chk("x_rd_gnt0", gnt0, 0);
        @(negedge clk); drv1(1'b0, 1'b0, 8'h00, 16'h0);
        @(negedge clk);
        #1 chk("x_rv1", rvalid1, 1); chk("x_rdata", rdata, 16'h1234);
        chk("x_rv0_off", rvalid0, 0);

        // both requesting from idle: burst limit alternation
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drv0(1'b1, 1'b0, 8'h00, 16'h0); drv1(1'b1, 1'b0, 8'h01, 16'h0);
`ifdef DMEM_ARB_FIXED_PRIO_EN
            e1 = 1'b0;
`else
            e1 = ((i / 4) % 2) == 1;
`endif
            #1 chk($sformatf("burst_gnt0_%0d", i), gnt0, !e1);
            chk($sformatf("burst_gnt1_%0d", i), gnt1, e1);
        end
        @(negedge clk); drv0(1'b0, 1'b0, 8'h00, 16'h0); drv1(1'b0, 1'b0, 8'h00, 16'h0);
        repeat (3) @(negedge clk);

        // write then same-address read on port 0 back to back
        drv0(1'b1, 1'b1, 8'h20, 16'h5A5A);
        #1 chk("raw_wr_gnt0", gnt0, 1);
        @(negedge clk); drv0(1'b1, 1'b0, 8'h20, 16'h0);
        #1 chk("raw_rd_gnt0", gnt0, 1);
        @(negedge clk); drv0(1'b0, 1'b0, 8'h00, 16'h0);
        @(negedge clk);
        #1 chk("raw_rv0", rvalid0, 1); chk("raw_rdata", rdata, 16'h5A5A);
        repeat (2) @(negedge clk);

        // back-to-back reads on port 1 of preloaded words
        for (int j = 0; j < 6; j++) begin
            if (j < 3) drv1(1'b1, 1'b0, 8'(j), 16'h0);
            else       drv1(1'b0, 1'b0, 8'h00, 16'h0);
            #1;
            if (j < 3) chk($sformatf("seq_gnt1_%0d", j), gnt1, 1);
            if (j >= 2 && j <= 4) begin
                chk($sformatf("seq_rv1_%0d", j), rvalid1, 1);
                chk($sformatf("seq_rdata_%0d", j), rdata, 32'(j - 1));
            end
            if (j == 5) begin
                chk("seq_rv1_end", rvalid1, 0);
                chk("seq_rdata_hold", rdata, 16'h0003);
            end
            @(negedge clk);
        end

        // reset right after a write grant, with a port 1 read in flight
        drv1(1'b1, 1'b0, 8'h00, 16'h0);
        #1 chk("ab_rd_gnt1", gnt1, 1);
        @(negedge clk); drv1(1'b0, 1'b0, 8'h00, 16'h0); drv0(1'b1, 1'b1, 8'h30, 16'hBEEF);
        #1 chk("ab_wr_gnt0", gnt0, 1);
        #2 rst_n = 1'b0;
        #1 chk("ab_gnt0", gnt0, 0); chk("ab_mem_en", mem_en, 0);
        chk("ab_rdata", rdata, 0); chk("ab_mem_addr", mem_addr, 0);
        chk("ab_mem_in", mem_in, 0); chk("ab_rv1", rvalid1, 0);
        @(posedge clk);
        #1 chk("ab_mem_en_edge", mem_en, 0); chk("ab_rv1_edge", rvalid1, 0);
        @(negedge clk); rst_n = 1'b1; drv0(1'b0, 1'b0, 8'h00, 16'h0);
        #1 chk("ab_rel_mem_en", mem_en, 0);
        @(negedge clk);
        #1 chk("ab_mem_kept", mem[8'h30], 16'h1111); chk("ab_rv1_after", rvalid1, 0);
        drv0(1'b1, 1'b0, 8'h00, 16'h0); drv1(1'b1, 1'b0, 8'h01, 16'h0);
        #1 chk("ab_tie_gnt0", gnt0, 1); chk("ab_tie_gnt1", gnt1, 0);
        @(negedge clk); drv0(1'b0, 1'b0, 8'h00, 16'h0); drv1(1'b0, 1'b0, 8'h00, 16'h0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 8, data memory address width.
REQ-002 Parameter: DATA_W, 16, data memory word width.
REQ-003 Parameter: MAX_BURST, 4, max consecutive grants to one port while the other waits; legal range 1..15.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req0, req1  input  1 each  access request from port 0 / port 1.
REQ-007 we0, we1  input  1 each  1 = write, 0 = read; qualified by reqN.
REQ-008 addr0, addr1  input  ADDR_W each  access address.
REQ-009 wdata0, wdata1  input  DATA_W each  write data.
REQ-010 gnt0, gnt1  output  1 each  combinational; request accepted this cycle.
REQ-011 rvalid0, rvalid1  output  1 each  registered; one-cycle pulse, rdata valid for that port.
REQ-012 rdata  output  DATA_W  registered read data shared by both ports.
REQ-013 mem_en  output  1  registered write enable to datamem.
REQ-014 mem_addr  output  ADDR_W  registered address to datamem.
REQ-015 mem_in  output  DATA_W  registered write data to datamem.
REQ-016 mem_out  input  DATA_W  combinational read data from datamem at mem_addr.

Function
REQ-017 Requester holds reqN, weN, addrN, wdataN stable until gntN is sampled high; deasserting reqN before grant is legal and withdraws the request.
REQ-018 At most one of gnt0/gnt1 is high in any cycle; gntN is never high while reqN is low.
REQ-019 One grant per cycle max; back-to-back grants, same or alternating ports, at full rate with no bubble.
REQ-020 Grant cycle T: winner's command is registered into mem_addr/mem_in at end of T; mem_en is high in T+1 only for a write, otherwise 0.
REQ-021 Read: mem_out is captured into rdata at end of T+1; rvalidN is high in T+2 only; read latency is 2 cycles gnt-to-rvalid.
REQ-022 Write granted at T followed by a read of the same address granted at T+1 returns the new data.
REQ-023 Ownership FSM states: IDLE (no grant last cycle), OWN0, OWN1; the next state is the owner of the current grant, or IDLE if none.
REQ-024 Burst counter: increments on each grant to the current owner, resets to 1 when ownership changes, and clears in IDLE.
REQ-025 Arbitration, only one requesting: that port wins.
REQ-026 Arbitration, both requesting, in OWNn with counter < MAX_BURST: port n wins.
REQ-027 Arbitration, both requesting, in OWNn with counter = MAX_BURST: the other port wins.
REQ-028 Arbitration, both requesting, in IDLE: the port not granted most recently wins (last-grant pointer).
REQ-029 rdata holds its last value when no read completes; rvalid0/rvalid1 are never high together.

Reset
REQ-030 rst_n low asynchronously forces gnt0=gnt1=0, rvalid0=rvalid1=0, rdata=0, mem_en=0, mem_addr=0, mem_in=0, FSM=IDLE, counter=0, last-grant pointer=port 1.
REQ-031 Reset mid-operation aborts in-flight accesses: a write registered but not yet performed never asserts mem_en, and a pending read never asserts rvalid.
REQ-032 After rst_n deasserts, the first grant is possible in the first clock cycle with rst_n high; the first tie goes to port 0.

Configuration
REQ-033 Macro DMEM_ARB_FIXED_PRIO_EN defined: port 0 always wins when both request, and burst counter and pointer are not used for arbitration.
REQ-034 Macro DMEM_ARB_FIXED_PRIO_EN undefined: round-robin with burst limit per REQ-025..REQ-028; latency and all other behaviour are identical.

Verification
REQ-035 Reset, then req0 write addr 0x05 data 0xABCD at T -> gnt0 at T, mem_en=1, mem_addr=0x05, mem_in=0xABCD at T+1; then req0 read 0x05 -> rvalid0 2 cycles after gnt0, rdata=0xABCD.
REQ-036 req0 write 0x10=0x1234 at T, req1 read 0x10 at T+1 -> gnt1 at T+1, rvalid1 at T+3, rdata=0x1234.
REQ-037 Both req held continuously from IDLE, MAX_BURST=4, macro undefined -> grants 0,0,0,0,1,1,1,1,0,... with no idle cycles.
REQ-038 Same stimulus with DMEM_ARB_FIXED_PRIO_EN defined -> gnt0 every cycle, gnt1 never.
REQ-039 rst_n pulsed low in the cycle after a write grant -> mem_en stays 0, memory contents unchanged, all outputs 0 during reset.
REQ-040 Reads of 0x00, 0x01, 0x02 from port 1 back-to-back, memory preloaded 0x0001/0x0002/0x0003 -> rvalid1 three consecutive cycles, rdata 0x0001, 0x0002, 0x0003.
